// File: rtl/cheri_pkg.sv
// Shared types and constants for the CHERIoT background-engine LSU responder.
package cheri_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    REQ1 = 3'd2,
    WRSP = 3'd3,
    ERR  = 3'd4
  } bglsu_state_e;

  localparam logic [31:0] CAP_MSW_OFFSET = 32'd4;
  localparam logic [3:0]  OBI_BE_WORD    = 4'hf;

  // Word accesses need 4-byte alignment, capabilities need 8-byte alignment.
  function automatic logic bglsu_misaligned(input logic [31:0] addr, input logic is_cap);
    return (addr[1:0] != 2'b00) || (is_cap && addr[2]);
  endfunction

endpackage

// File: rtl/cheri_bglsu_resp.sv
// Responder for background-engine (TBRE/STKZ) LSU requests. Runs one word or
// one capability (two words, LSW then MSW) on the OBI data bus at a time,
// yielding to the CPU LSU whenever it is busy at accept time.
module cheri_bglsu_resp
  import cheri_pkg::*;
#(
  parameter bit CHERIoTEn = 1'b1,
  parameter bit AlignChk  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tbre_lsu_req_i,
  input  logic        tbre_lsu_is_cap_i,
  input  logic        tbre_lsu_we_i,
  input  logic [31:0] tbre_lsu_addr_i,
  input  logic [32:0] tbre_lsu_wdata_i,
  input  logic        cpu_lsu_busy_i,
  output logic        lsu_tbre_sel_o,
  output logic        lsu_tbre_req_done_o,
  output logic        lsu_tbre_addr_incr_o,
  output logic        lsu_tbre_resp_valid_o,
  output logic        lsu_tbre_resp_err_o,
  output logic        lsu_tbre_resp_is_wr_o,
  output logic [32:0] lsu_tbre_raw_lsw_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [32:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [32:0] data_rdata_i
);

  bglsu_state_e state_q, state_d;

  logic [31:0] addr_q;
  logic        we_q, cap_q, err_q, w0_seen_q, err_ph_q;
  logic [32:0] lsw_q;
  logic [1:0]  outst_q;

  logic        accept, misal, bus_req, gnt_ok, rv_ok, resp_bus;
  logic [31:0] word_addr;

  // When the feature is disabled nothing is ever accepted, so every output
  // stays at its reset value.
  assign accept   = CHERIoTEn && (state_q == IDLE) && tbre_lsu_req_i && !cpu_lsu_busy_i;
  assign misal    = AlignChk && bglsu_misaligned(tbre_lsu_addr_i, tbre_lsu_is_cap_i);
  assign bus_req  = (state_q == REQ0) || (state_q == REQ1);
  assign gnt_ok   = bus_req && data_gnt_i;
  // rvalid only counts against our own outstanding grants; stale responses
  // arriving after a reset land in IDLE with outst_q == 0 and are dropped.
  assign rv_ok    = data_rvalid_i && (outst_q != 2'd0) &&
                    ((state_q == REQ1) || (state_q == WRSP));
  // The last response is the one that drains the outstanding counter in WRSP.
  assign resp_bus = (state_q == WRSP) && rv_ok && (outst_q == 2'd1);
  assign word_addr = (state_q == REQ1) ? (addr_q + CAP_MSW_OFFSET) : addr_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = misal ? ERR : REQ0;
      REQ0:    if (data_gnt_i) state_d = cap_q ? REQ1 : WRSP;
      REQ1:    if (data_gnt_i) state_d = WRSP;
      WRSP:    if (resp_bus) state_d = IDLE;
      ERR:     if (err_ph_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction context, error accumulation, word-0 capture and outstanding count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      cap_q     <= 1'b0;
      err_q     <= 1'b0;
      w0_seen_q <= 1'b0;
      lsw_q     <= '0;
      outst_q   <= '0;
      err_ph_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= tbre_lsu_addr_i;
        we_q      <= tbre_lsu_we_i;
        cap_q     <= tbre_lsu_is_cap_i;
        err_q     <= 1'b0;
        w0_seen_q <= 1'b0;
        lsw_q     <= '0;
      end
      if (rv_ok) begin
        err_q     <= err_q | data_err_i;
        w0_seen_q <= 1'b1;
        if (!w0_seen_q) lsw_q <= data_rdata_i;
      end
      case ({gnt_ok, rv_ok})
        2'b10:   outst_q <= outst_q + 2'd1;
        2'b01:   outst_q <= outst_q - 2'd1;
        default: outst_q <= outst_q;
      endcase
      // ERR spends one cycle reporting req_done, then one reporting the response.
      err_ph_q <= (state_q == ERR) && !err_ph_q;
    end
  end

  // Outputs: bus drive, handshake pulses and response fields, all zero when idle
  always_comb begin
    lsu_tbre_sel_o        = (state_q != IDLE);
    lsu_tbre_req_done_o   = 1'b0;
    lsu_tbre_addr_incr_o  = 1'b0;
    lsu_tbre_resp_valid_o = 1'b0;
    lsu_tbre_resp_err_o   = 1'b0;
    lsu_tbre_resp_is_wr_o = 1'b0;
    lsu_tbre_raw_lsw_o    = '0;
    data_req_o            = bus_req;
    data_we_o             = 1'b0;
    data_be_o             = '0;
    data_addr_o           = '0;
    data_wdata_o          = '0;

    if (bus_req) begin
      data_we_o    = we_q;
      data_be_o    = OBI_BE_WORD;
      data_addr_o  = {word_addr[31:2], 2'b00};
      data_wdata_o = tbre_lsu_wdata_i;
    end

    case (state_q)
      REQ0: begin
        lsu_tbre_req_done_o  = data_gnt_i && !cap_q;
        lsu_tbre_addr_incr_o = data_gnt_i && cap_q;
      end
      REQ1: lsu_tbre_req_done_o = data_gnt_i;
      ERR: begin
        lsu_tbre_req_done_o   = !err_ph_q;
        lsu_tbre_resp_valid_o = err_ph_q;
        lsu_tbre_resp_err_o   = err_ph_q;
        lsu_tbre_resp_is_wr_o = err_ph_q && we_q;
      end
      default: ;
    endcase

    if (resp_bus) begin
      lsu_tbre_resp_valid_o = 1'b1;
      lsu_tbre_resp_err_o   = err_q | data_err_i;
      lsu_tbre_resp_is_wr_o = we_q;
      lsu_tbre_raw_lsw_o    = we_q ? 33'd0 : (cap_q ? lsw_q : data_rdata_i);
    end
  end

endmodule

// File: tb/tb_cheri_bglsu_resp.sv
// Directed bench for cheri_bglsu_resp: a vector table of complete transactions
// plus hand-written sequences for CPU-busy hold-off, cancel and mid-flight reset.
module tb_cheri_bglsu_resp;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        tbre_lsu_req_i, tbre_lsu_is_cap_i, tbre_lsu_we_i;
  logic [31:0] tbre_lsu_addr_i;
  logic [32:0] tbre_lsu_wdata_i;
  logic        cpu_lsu_busy_i;
  logic        lsu_tbre_sel_o, lsu_tbre_req_done_o, lsu_tbre_addr_incr_o;
  logic        lsu_tbre_resp_valid_o, lsu_tbre_resp_err_o, lsu_tbre_resp_is_wr_o;
  logic [32:0] lsu_tbre_raw_lsw_o;
  logic        data_req_o, data_gnt_i, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [32:0] data_wdata_o;
  logic        data_rvalid_i, data_err_i;
  logic [32:0] data_rdata_i;

  cheri_bglsu_resp dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tbre_lsu_req_i(tbre_lsu_req_i), .tbre_lsu_is_cap_i(tbre_lsu_is_cap_i),
    .tbre_lsu_we_i(tbre_lsu_we_i), .tbre_lsu_addr_i(tbre_lsu_addr_i),
    .tbre_lsu_wdata_i(tbre_lsu_wdata_i), .cpu_lsu_busy_i(cpu_lsu_busy_i),
    .lsu_tbre_sel_o(lsu_tbre_sel_o), .lsu_tbre_req_done_o(lsu_tbre_req_done_o),
    .lsu_tbre_addr_incr_o(lsu_tbre_addr_incr_o),
    .lsu_tbre_resp_valid_o(lsu_tbre_resp_valid_o),
    .lsu_tbre_resp_err_o(lsu_tbre_resp_err_o),
    .lsu_tbre_resp_is_wr_o(lsu_tbre_resp_is_wr_o),
    .lsu_tbre_raw_lsw_o(lsu_tbre_raw_lsw_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_rdata_i(data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_vec = -1;

  typedef struct {
    logic        cap;
    logic        we;
    logic [31:0] addr;
    logic [32:0] wd0, wd1, rd0, rd1;
    logic        e0, e1;
    int          gw0, gw1;   // gnt wait cycles for word 0 / word 1
    logic        r0e;        // word-0 rvalid in first REQ1 cycle
    int          rdly;       // idle cycles before the final rvalid
    logic        mis;
    logic        exp_err;
    logic [32:0] exp_lsw;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL v%0d %s: got %h expected %h", cur_vec, name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_sel"},   lsu_tbre_sel_o, 0);
    chk({tag, "_done"},  lsu_tbre_req_done_o, 0);
    chk({tag, "_incr"},  lsu_tbre_addr_incr_o, 0);
    chk({tag, "_rv"},    lsu_tbre_resp_valid_o, 0);
    chk({tag, "_err"},   lsu_tbre_resp_err_o, 0);
    chk({tag, "_iswr"},  lsu_tbre_resp_is_wr_o, 0);
    chk({tag, "_lsw"},   lsu_tbre_raw_lsw_o, 0);
    chk({tag, "_req"},   data_req_o, 0);
    chk({tag, "_we"},    data_we_o, 0);
    chk({tag, "_be"},    data_be_o, 0);
    chk({tag, "_addr"},  data_addr_o, 0);
    chk({tag, "_wdata"}, data_wdata_o, 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [32:0] rd_last;
    logic        e_last;
    step();
    tbre_lsu_req_i = 1'b1; tbre_lsu_is_cap_i = v.cap; tbre_lsu_we_i = v.we;
    tbre_lsu_addr_i = v.addr; tbre_lsu_wdata_i = v.wd0;
    #3 chk("acc_noreq", data_req_o, 0);
    step();
    if (v.mis) begin
      #3;
      chk("err_done", lsu_tbre_req_done_o, 1);
      chk("err_noreq", data_req_o, 0);
      chk("err_nrv", lsu_tbre_resp_valid_o, 0);
      step();
      tbre_lsu_req_i = 1'b0;
      #3;
      chk("err_rv", lsu_tbre_resp_valid_o, 1);
      chk("err_err", lsu_tbre_resp_err_o, 1);
      chk("err_iswr", lsu_tbre_resp_is_wr_o, v.we);
      chk("err_noreq2", data_req_o, 0);
      chk("err_done2", lsu_tbre_req_done_o, 0);
      step();
      #3 chk("err_idle", lsu_tbre_sel_o, 0);
      return;
    end
    for (int w = 0; w <= v.gw0; w++) begin
      data_gnt_i = (w == v.gw0);
      #3;
      chk("req0_req", data_req_o, 1);
      chk("req0_addr", data_addr_o, v.addr);
      chk("req0_we", data_we_o, v.we);
      chk("req0_be", data_be_o, 4'hf);
      chk("req0_wdata", data_wdata_o, v.wd0);
      chk("req0_done", lsu_tbre_req_done_o, data_gnt_i && !v.cap);
      chk("req0_incr", lsu_tbre_addr_incr_o, data_gnt_i && v.cap);
      step();
    end
    data_gnt_i = 1'b0;
    if (v.cap) begin
      tbre_lsu_wdata_i = v.wd1;
      for (int w = 0; w <= v.gw1; w++) begin
        data_gnt_i    = (w == v.gw1);
        data_rvalid_i = (w == 0) && v.r0e;
        data_rdata_i  = data_rvalid_i ? v.rd0 : 33'd0;
        data_err_i    = data_rvalid_i && v.e0;
        #3;
        chk("req1_req", data_req_o, 1);
        chk("req1_addr", data_addr_o, v.addr + 32'd4);
        chk("req1_wdata", data_wdata_o, v.wd1);
        chk("req1_done", lsu_tbre_req_done_o, data_gnt_i);
        chk("req1_incr", lsu_tbre_addr_incr_o, 0);
        chk("req1_nrv", lsu_tbre_resp_valid_o, 0);
        step();
      end
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
    end
    tbre_lsu_req_i = 1'b0;
    if (v.cap && !v.r0e) begin
      data_rvalid_i = 1'b1; data_rdata_i = v.rd0; data_err_i = v.e0;
      #3;
      chk("w0_nrv", lsu_tbre_resp_valid_o, 0);
      chk("w0_sel", lsu_tbre_sel_o, 1);
      step();
      data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
    end
    for (int d = 0; d < v.rdly; d++) begin
      #3;
      chk("wait_nrv", lsu_tbre_resp_valid_o, 0);
      chk("wait_noreq", data_req_o, 0);
      chk("wait_sel", lsu_tbre_sel_o, 1);
      step();
    end
    rd_last = v.cap ? v.rd1 : v.rd0;
    e_last  = v.cap ? v.e1 : v.e0;
    data_rvalid_i = 1'b1; data_rdata_i = rd_last; data_err_i = e_last;
    #3;
    chk("rsp_valid", lsu_tbre_resp_valid_o, 1);
    chk("rsp_err", lsu_tbre_resp_err_o, v.exp_err);
    chk("rsp_iswr", lsu_tbre_resp_is_wr_o, v.we);
    chk("rsp_lsw", lsu_tbre_raw_lsw_o, v.exp_lsw);
    step();
    data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
    #3;
    chk("rsp_idle", lsu_tbre_sel_o, 0);
    chk("rsp_pulse", lsu_tbre_resp_valid_o, 0);
  endtask

  initial begin
    //            cap   we    addr          wd0            wd1            rd0            rd1            e0    e1   gw0 gw1 r0e   rdly mis   err   lsw
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0200, 33'h0,         33'h0,         33'h0_1234_5678, 33'h0,       1'b0, 1'b0, 0, 0, 1'b0, 1, 1'b0, 1'b0, 33'h0_1234_5678};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_1000, 33'h1_AAAA_0000, 33'h0_5555_FFFF, 33'h0_0BAD_0BAD, 33'h1_FFFF_FFFF, 1'b0, 1'b0, 0, 1, 1'b0, 0, 1'b0, 1'b0, 33'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_2000, 33'h0,         33'h0,         33'h1_DEAD_BEEF, 33'h0_0000_1111, 1'b0, 1'b1, 1, 0, 1'b1, 0, 1'b0, 1'b1, 33'h1_DEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_1004, 33'h0,         33'h0,         33'h0,         33'h0,         1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1, 33'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0003, 33'h0,         33'h0,         33'h0,         33'h0,         1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1, 33'h0};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_1002, 33'h1_0000_0001, 33'h0,       33'h0,         33'h0,         1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1, 33'h0};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0300, 33'h1_7777_8888, 33'h0,       33'h1_2222_3333, 33'h0,       1'b1, 1'b0, 3, 0, 1'b0, 2, 1'b0, 1'b1, 33'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0040, 33'h0,         33'h0,         33'h0_CAFE_F00D, 33'h1_0000_0001, 1'b1, 1'b0, 2, 2, 1'b0, 2, 1'b0, 1'b1, 33'h0_CAFE_F00D};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_FFF8, 33'h0,         33'h0,         33'h1_1111_2222, 33'h0_3333_4444, 1'b0, 1'b0, 0, 2, 1'b1, 1, 1'b0, 1'b0, 33'h1_1111_2222};
    vecs[9] = '{1'b0, 1'b0, 32'h0000_07FC, 33'h0,         33'h0,         33'h1_ABCD_EF01, 33'h0,       1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 33'h1_ABCD_EF01};

    // Reset with busy-looking inputs: every output must still read zero.
    rst_ni = 1'b0;
    tbre_lsu_req_i = 1'b1; tbre_lsu_is_cap_i = 1'b0; tbre_lsu_we_i = 1'b1;
    tbre_lsu_addr_i = 32'h100; tbre_lsu_wdata_i = 33'h1_2345_6789;
    cpu_lsu_busy_i = 1'b0; data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
    data_err_i = 1'b1; data_rdata_i = 33'h1_5A5A_5A5A;
    repeat (2) @(posedge clk_i);
    #3 chk_quiet("rst");
    tbre_lsu_req_i = 1'b0; tbre_lsu_we_i = 1'b0; tbre_lsu_addr_i = '0;
    tbre_lsu_wdata_i = '0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    data_err_i = 1'b0; data_rdata_i = '0;
    step();
    rst_ni = 1'b1;
    step();
    #3 chk_quiet("post_rst");

    for (int i = 0; i < NV; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // CPU busy for 5 cycles with req held: nothing issued until busy drops.
    cur_vec = 100;
    step();
    tbre_lsu_req_i = 1'b1; tbre_lsu_is_cap_i = 1'b0; tbre_lsu_we_i = 1'b0;
    tbre_lsu_addr_i = 32'h500; cpu_lsu_busy_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #3;
      chk("busy_noreq", data_req_o, 0);
      chk("busy_sel", lsu_tbre_sel_o, 0);
      step();
    end
    cpu_lsu_busy_i = 1'b0;
    #3 chk("busy_acc", data_req_o, 0);
    step();
    cpu_lsu_busy_i = 1'b1;  // ignored once the bus is owned
    data_gnt_i = 1'b1;
    #3;
    chk("busy_req", data_req_o, 1);
    chk("busy_addr", data_addr_o, 32'h500);
    chk("busy_done", lsu_tbre_req_done_o, 1);
    step();
    data_gnt_i = 1'b0; tbre_lsu_req_i = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 33'h0_0000_0500;
    #3;
    chk("busy_rv", lsu_tbre_resp_valid_o, 1);
    chk("busy_lsw", lsu_tbre_raw_lsw_o, 33'h0_0000_0500);
    step();
    data_rvalid_i = 1'b0; data_rdata_i = '0; cpu_lsu_busy_i = 1'b0;

    // Request withdrawn while the CPU is busy: nothing ever issues.
    cur_vec = 101;
    tbre_lsu_req_i = 1'b1; cpu_lsu_busy_i = 1'b1;
    #3 chk("cancel_sel0", lsu_tbre_sel_o, 0);
    step();
    tbre_lsu_req_i = 1'b0; cpu_lsu_busy_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("cancel_noreq", data_req_o, 0);
      chk("cancel_sel", lsu_tbre_sel_o, 0);
      step();
    end

    // Reset asserted in REQ1 clears outputs asynchronously; stale rvalid ignored.
    cur_vec = 102;
    tbre_lsu_req_i = 1'b1; tbre_lsu_is_cap_i = 1'b1; tbre_lsu_we_i = 1'b1;
    tbre_lsu_addr_i = 32'h800; tbre_lsu_wdata_i = 33'h1_0000_0800;
    step();
    data_gnt_i = 1'b1;
    #3 chk("mrst_incr", lsu_tbre_addr_incr_o, 1);
    step();
    data_gnt_i = 1'b0; tbre_lsu_wdata_i = 33'h0_0000_0804;
    #3;
    chk("mrst_req1", data_req_o, 1);
    chk("mrst_addr1", data_addr_o, 32'h804);
    rst_ni = 1'b0;
    #1 chk_quiet("mrst_async");
    tbre_lsu_req_i = 1'b0; tbre_lsu_is_cap_i = 1'b0; tbre_lsu_we_i = 1'b0;
    step();
    rst_ni = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 33'h1_FEED_FACE;
    #3;
    chk("mrst_idle", lsu_tbre_sel_o, 0);
    chk("mrst_stale_rv", lsu_tbre_resp_valid_o, 0);
    chk("mrst_stale_lsw", lsu_tbre_raw_lsw_o, 0);
    step();
    data_rvalid_i = 1'b0; data_rdata_i = '0;

    // Recovery: a normal transaction runs cleanly after the reset.
    cur_vec = 0;
    run_vec(vecs[0]);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
